// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source sync, polarity, level/edge latch, mask and priority vector.
// Bus slave with a two-cycle en/wr/addr handshake (wt high in the first cycle).
module irq_ctrl #(
   parameter int unsigned NSRC        = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] RESET_MASK  = 32'h0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            wr,
   input  logic [2:0]      addr,
   input  logic [31:0]     data_in,
   output logic [31:0]     data_out,
   output logic            wt,
   input  logic [NSRC-1:0] src,
   output logic [NSRC-1:0] irq
);

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_POL     = 3'd3;
   localparam logic [2:0] ADDR_VECTOR  = 3'd4;
   localparam logic [2:0] ADDR_SWSET   = 3'd5;

   logic            r_ack;
   logic            r_primed;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_mode;
   logic [NSRC-1:0] r_pol;
   logic [NSRC-1:0] r_prev;
   logic [NSRC-1:0] r_irq;

   logic [NSRC-1:0] w_s;
   logic [NSRC-1:0] w_sync;
   logic [NSRC-1:0] w_edge;
   logic [NSRC-1:0] w_wdata;
   logic [NSRC-1:0] w_set;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_pending_d;
   logic [NSRC-1:0] w_masked;
   logic            w_wr_commit;
   logic            w_vec_any;
   logic [4:0]      w_vec_idx;
   logic [31:0]     w_rdata;
   logic            w_unused_data;

   assign w_s           = src ^ r_pol;
   assign w_wdata       = data_in[NSRC-1:0];
   assign w_unused_data = ^data_in;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = w_s;
   end else begin : g_sync
      logic [NSRC-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         end else begin
            r_sync[0] <= w_s;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         end
      end

      assign w_sync = r_sync[SYNC_STAGES-1];
   end

   // Writes commit on the edge that ends the second (acknowledged) cycle.
   assign w_wr_commit = r_ack & en & wr;
   assign wt          = en & ~r_ack;

   // No edge events until one cycle after reset, so lines already active at reset stay quiet.
   assign w_edge = w_sync & ~r_prev & {NSRC{r_primed}};
   assign w_set  = w_edge | ((w_wr_commit && addr == ADDR_SWSET) ? w_wdata : '0);
   assign w_clr  = (w_wr_commit && addr == ADDR_PENDING) ? w_wdata : '0;

   // Set beats write-1-clear in edge mode; level bits just follow the synchronised line.
   assign w_pending_d = (r_mode & (w_set | (r_pending & ~w_clr))) | (~r_mode & w_sync);
   assign w_masked    = r_pending & r_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack     <= 1'b0;
         r_primed  <= 1'b0;
         r_pending <= '0;
         r_mask    <= RESET_MASK[NSRC-1:0];
         r_mode    <= '0;
         r_pol     <= '0;
         r_prev    <= '0;
         r_irq     <= '0;
      end else begin
         r_ack     <= en & ~r_ack;
         r_primed  <= 1'b1;
         r_prev    <= w_sync;
         r_pending <= w_pending_d;
         r_irq     <= w_masked;
         if (w_wr_commit) begin
            case (addr)
               ADDR_MASK: r_mask <= w_wdata;
               ADDR_MODE: r_mode <= w_wdata;
               ADDR_POL:  r_pol  <= w_wdata;
               default:   ;
            endcase
         end
      end
   end

   // Highest set index wins.
   always_comb begin
      w_vec_idx = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (w_masked[i]) w_vec_idx = 5'(i);
      end
   end

   assign w_vec_any = |w_masked;

   always_comb begin
      w_rdata = '0;
      case (addr)
         ADDR_PENDING: w_rdata = 32'(r_pending);
         ADDR_MASK:    w_rdata = 32'(r_mask);
         ADDR_MODE:    w_rdata = 32'(r_mode);
         ADDR_POL:     w_rdata = 32'(r_pol);
         ADDR_VECTOR:  w_rdata = {w_vec_any, 26'b0, w_vec_idx};
         default:      w_rdata = '0;
      endcase
   end

   assign data_out = r_ack ? w_rdata : '0;
   assign irq      = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a 16-source, 2-stage instance and a 5-source, unsynchronised one.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        wr = 1'b0;
   logic        sel = 1'b0;
   logic [2:0]  addr = '0;
   logic [31:0] data_in = '0;

   logic        en_a, en_b;
   logic [31:0] data_out_a, data_out_b;
   logic        wt_a, wt_b;
   logic [15:0] src_a = '0;
   logic [15:0] irq_a;
   logic [4:0]  src_b = '0;
   logic [4:0]  irq_b;

   int checks = 0;
   int errors = 0;

   assign en_a = en & ~sel;
   assign en_b = en & sel;

   always #5 clk = ~clk;

   irq_ctrl #(.NSRC(16), .SYNC_STAGES(2), .RESET_MASK(32'h0)) dut_a (
      .clk(clk), .reset(reset), .en(en_a), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(data_out_a), .wt(wt_a), .src(src_a), .irq(irq_a)
   );

   irq_ctrl #(.NSRC(5), .SYNC_STAGES(0), .RESET_MASK(32'hFFFF_FFE3)) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(data_out_b), .wt(wt_b), .src(src_b), .irq(irq_b)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Entered and left 1 time unit after a rising edge.
   task automatic bus(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic wt1, output logic wt2);
      sel = s; wr = w; addr = a; data_in = d; en = 1'b1;
      @(negedge clk);
      wt1 = s ? wt_b : wt_a;
      @(posedge clk);
      @(negedge clk);
      wt2 = s ? wt_b : wt_a;
      q   = s ? data_out_b : data_out_a;
      @(posedge clk);
      #1;
      en = 1'b0; wr = 1'b0;
   endtask

   task automatic do_reset();
      en = 1'b0; reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      checks++;
      if (irq_a !== 16'h0 || wt_a !== 1'b0 || data_out_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_idle: irq=%h wt=%b dout=%h, required 0/0/0", irq_a, wt_a, data_out_a);
      end
      for (int a = 0; a < 8; a++) begin
         bus(1'b0, 1'b0, 3'(a), 32'h0, q, w1, w2);
         checks++;
         if (q !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h required 00000000", a, q);
         end
         checks++;
         if (w1 !== 1'b1 || w2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wt%0d: got %b%b required 10", a, w1, w2);
         end
      end
      bus(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, q, w1, w2);
      bus(1'b0, 1'b0, 3'd7, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL reg7_write_ignored: got %h required 00000000", q);
      end
      bus(1'b1, 1'b0, 3'd1, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0003) begin
         errors++;
         $display("FAIL reset_mask_b: got %h required 00000003", q);
      end
   endtask

   task automatic test_level();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      bus(1'b0, 1'b1, 3'd1, 32'h0000_0010, q, w1, w2);
      src_a[4] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0) begin
         errors++;
         $display("FAIL level_irq_early: got %h required 0000", irq_a);
      end
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0010) begin
         errors++;
         $display("FAIL level_irq_rise: got %h required 0010", irq_a);
      end
      @(posedge clk);
      #1;
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0010) begin
         errors++;
         $display("FAIL level_pending: got %h required 00000010", q);
      end
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_0004) begin
         errors++;
         $display("FAIL level_vector: got %h required 80000004", q);
      end
      src_a[4] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0010) begin
         errors++;
         $display("FAIL level_irq_hold: got %h required 0010", irq_a);
      end
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0) begin
         errors++;
         $display("FAIL level_irq_fall: got %h required 0000", irq_a);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_edge();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      bus(1'b0, 1'b1, 3'd2, 32'h0000_0100, q, w1, w2);
      bus(1'b0, 1'b1, 3'd1, 32'h0000_0100, q, w1, w2);
      src_a[8] = 1'b1;
      tick(1);
      src_a[8] = 1'b0;
      tick(10);
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0100 || irq_a !== 16'h0100) begin
         errors++;
         $display("FAIL edge_latch: pending=%h irq=%h required 00000100/0100", q, irq_a);
      end
      bus(1'b0, 1'b1, 3'd0, 32'h0000_0100, q, w1, w2);
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL edge_clear: got %h required 00000000", q);
      end
      // New edge lands on the same clock edge as the write-1-clear commit.
      src_a[8] = 1'b1;
      tick(1);
      bus(1'b0, 1'b1, 3'd0, 32'h0000_0100, q, w1, w2);
      src_a[8] = 1'b0;
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0100) begin
         errors++;
         $display("FAIL edge_race: got %h required 00000100", q);
      end
   endtask

   task automatic test_priority_polarity();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      bus(1'b0, 1'b1, 3'd3, 32'h0000_0001, q, w1, w2);
      bus(1'b0, 1'b1, 3'd1, 32'h0000_FFFF, q, w1, w2);
      tick(5);
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_0000 || irq_a !== 16'h0001) begin
         errors++;
         $display("FAIL pol_active_low: vector=%h irq=%h required 80000000/0001", q, irq_a);
      end
      src_a[14] = 1'b1;
      tick(5);
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_000E || irq_a !== 16'h4001) begin
         errors++;
         $display("FAIL prio_high: vector=%h irq=%h required 8000000e/4001", q, irq_a);
      end
      src_a[14] = 1'b0;
      tick(5);
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_0000) begin
         errors++;
         $display("FAIL prio_drop: got %h required 80000000", q);
      end
      src_a[0] = 1'b1;
      tick(5);
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0 || irq_a !== 16'h0) begin
         errors++;
         $display("FAIL pol_inactive: vector=%h irq=%h required 00000000/0000", q, irq_a);
      end
      src_a[0] = 1'b0;
   endtask

   task automatic test_swset();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      bus(1'b0, 1'b1, 3'd2, 32'h0000_0008, q, w1, w2);
      bus(1'b0, 1'b1, 3'd5, 32'h0000_0008, q, w1, w2);
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0008 || irq_a !== 16'h0) begin
         errors++;
         $display("FAIL swset_masked: pending=%h irq=%h required 00000008/0000", q, irq_a);
      end
      bus(1'b0, 1'b0, 3'd5, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL swset_read: got %h required 00000000", q);
      end
      bus(1'b0, 1'b1, 3'd1, 32'h0000_0008, q, w1, w2);
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0) begin
         errors++;
         $display("FAIL swset_irq_early: got %h required 0000", irq_a);
      end
      @(negedge clk);
      checks++;
      if (irq_a !== 16'h0008) begin
         errors++;
         $display("FAIL swset_irq: got %h required 0008", irq_a);
      end
      @(posedge clk);
      #1;
      bus(1'b0, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_0003) begin
         errors++;
         $display("FAIL swset_vector: got %h required 80000003", q);
      end
      bus(1'b0, 1'b1, 3'd5, 32'h0000_0010, q, w1, w2);
      bus(1'b0, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_0008) begin
         errors++;
         $display("FAIL swset_level_ignored: got %h required 00000008", q);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] q;
      logic w1, w2;
      do_reset();
      // Reset during the acknowledged cycle of a MASK write; en stays high for a read.
      sel = 1'b0; wr = 1'b1; addr = 3'd1; data_in = 32'h0000_FFFF; en = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0; wr = 1'b0;
      @(negedge clk);
      checks++;
      if (wt_a !== 1'b1) begin
         errors++;
         $display("FAIL midreset_wt: got %b required 1", wt_a);
      end
      @(negedge clk);
      checks++;
      if (wt_a !== 1'b0 || data_out_a !== 32'h0) begin
         errors++;
         $display("FAIL midreset_discard: wt=%b mask=%h required 0/00000000", wt_a, data_out_a);
      end
      @(posedge clk);
      #1;
      en = 1'b0;
      // Reset in the first cycle of a MODE write.
      wr = 1'b1; addr = 3'd2; data_in = 32'h0000_00FF; en = 1'b1; reset = 1'b1;
      tick(1);
      reset = 1'b0; en = 1'b0; wr = 1'b0;
      tick(1);
      bus(1'b0, 1'b0, 3'd2, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL reset_cycle1_write: got %h required 00000000", q);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] q;
      logic w1, w2;
      src_b[0] = 1'b1;
      do_reset();
      bus(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, q, w1, w2);
      bus(1'b1, 1'b0, 3'd1, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0000_001F) begin
         errors++;
         $display("FAIL nsrc5_mask: got %h required 0000001f", q);
      end
      bus(1'b1, 1'b1, 3'd2, 32'h0000_0001, q, w1, w2);
      bus(1'b1, 1'b1, 3'd0, 32'h0000_0001, q, w1, w2);
      tick(4);
      bus(1'b1, 1'b0, 3'd0, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL held_line_no_event: got %h required 00000000", q);
      end
      src_b[0] = 1'b0;
      tick(2);
      src_b[0] = 1'b1;
      tick(3);
      bus(1'b1, 1'b0, 3'd4, 32'h0, q, w1, w2);
      checks++;
      if (q !== 32'h8000_0000 || irq_b !== 5'h01) begin
         errors++;
         $display("FAIL new_edge_b: vector=%h irq=%h required 80000000/01", q, irq_b);
      end
      src_b[0] = 1'b0;
   endtask

   initial begin
      tick(1);
      test_reset();
      test_level();
      test_edge();
      test_priority_polarity();
      test_swset();
      test_mid_reset();
      test_boundary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller placed between the device interrupt lines and the CPU `irq` input.
- It replaces the fixed per-line interrupt wiring in the top level.
- Each of NSRC sources is individually synchronised, polarity-adjusted, and configured as level or edge mode, and is latched, masked and prioritised.
- It is a bus slave using the standard en/wr/addr/data/wt protocol, with a vector register that returns the highest-priority pending source.

Parameters:
- NSRC, 16, number of interrupt sources (1..32); bit i of every register refers to source i.
- SYNC_STAGES, 2, synchroniser flops per source input (0..3); 0 means the inputs are already synchronous to clk.
- RESET_MASK, 32'h0, reset value of MASK (bits at index NSRC and above are ignored).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  bus access enable.
- wr  in  1  1 = write, 0 = read.
- addr  in  3 [4:2]  register select.
- data_in  in  32  write data.
- data_out  out  32  read data.
- wt  out  1  wait; the bus master holds its request while this is 1.
- src  in  NSRC  raw interrupt source lines.
- irq  out  NSRC  masked pending interrupts, to the CPU.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. Everything below is registered on the rising edge of clk.
- Register map (addr[4:2]):
  - 0 PENDING: reads the pending bits; writing 1 clears the bit (edge-mode bits only; ignored for level-mode bits).
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 POLARITY: read/write; 1 = active-low.
  - 4 VECTOR: read-only. Bit 31 = any (pending & mask) bit set; bits [4:0] = index of the highest set bit of (pending & mask), or 0 when none. The highest index has the highest priority, matching the CPU convention.
  - 5 SWSET: write-only, reads 0; writing 1 sets the pending bit (edge-mode bits only).
  - 6, 7: read 0, writes ignored.
- Register bits at index NSRC..31 read 0 and ignore writes.
- Bus handshake:
  - Internal flag `ack` <= en & ~ack.
  - wt = en & ~ack (combinational).
  - Every access therefore takes 2 cycles: wt=1 in cycle 1, wt=0 in cycle 2.
  - Writes commit at the clock edge ending cycle 2. data_out is valid during cycle 2 and is 0 whenever ack=0.
  - If en stays high, a new access starts in cycle 3.
- Source path:
  - s = src ^ POLARITY, passed through SYNC_STAGES flops to give `sync`.
  - prev <= sync.
  - Level mode: pending[i] <= sync[i].
  - Edge mode: pending[i] is set when sync[i] & ~prev[i], and stays set until cleared.
- Priority within one cycle for an edge-mode bit: reset > (hardware edge or SWSET) > write-1-clear. A set and a clear landing on the same edge leave the bit set.
- Mode switch:
  - Level to edge: pending starts from its current value.
  - Edge to level: pending follows `sync` from the next edge.
- Polarity change: can create an edge in `sync`. Software masks the source before changing polarity; the hardware does not suppress it.
- Output: irq <= pending & MASK (registered).
- Latency from an src change (with SYNC_STAGES = S) to a visible response:
  - pending updates S+1 cycles later.
  - irq updates S+2 cycles later.
  - For S = 0, pending updates 1 cycle later and irq 2 cycles later.
- Reset values:
  - PENDING, MODE, POLARITY, the sync flops, ack and irq: 0.
  - prev: 0.
  - MASK: RESET_MASK.
  - data_out: 0; wt: 0.
- Post-reset priming: a 1-bit `primed` flag is cleared by reset and set on the first cycle after reset. While primed = 0, no edge events are generated, so a line that is already active at reset does not fire in edge mode.
- Reset mid-access: ack clears and any write in flight is discarded. If en is still high, wt reads 1 in the next cycle.

Test Plan:
- Reset values: reset for 2 cycles, then read each register → PENDING=0, MASK=RESET_MASK, MODE=0, VECTOR=0. Check wt=1 then 0 on every access; irq=0.
- Level mode: MASK=0x0010, SYNC_STAGES=2. Raise src[4] at cycle t → PENDING[4]=1 at t+3, irq=0x0010 at t+4, VECTOR=0x80000004. Drop src[4] → irq=0 four cycles later.
- Edge, clear and race: MODE=MASK=0x0100. Pulse src[8] for 1 cycle → PENDING[8] latches and stays set. Write 0x0100 to PENDING → bit clears. Repeat with a new edge landing on the same edge as the clear → bit remains 1.
- Priority and polarity: POLARITY=0x0001, MASK=0xFFFF, src=0x0000. Source 0 becomes active. Also set src[14]=1 → VECTOR=0x8000000E. Clear src[14] → VECTOR=0x80000000.
- Software set and mask: MODE=0x0008, write 0x0008 to SWSET → PENDING=0x0008, irq=0 while MASK=0. Then MASK=0x0008 → irq=0x0008 one cycle after the write commits. Confirm SWSET on a level-mode bit has no effect.
- Boundaries: with NSRC=5, write 0xFFFFFFFF to MASK → reads 0x1F. With src[0] high during reset and MODE[0]=1 after reset → no pending event until an actual new rising edge. Assert reset in cycle 1 of a write → register unchanged.
